// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell and a carry flop add two
// WIDTH-bit operands LSB first, one bit per clock, behind a start/ready/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ss_q, ss_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit, c_bit;

  // Returns {carry, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ss_d    = ss_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    {c_bit, s_bit} = full_add(sa_q[0], sb_q[0], c_q);

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts start directly so operations can run back to back.
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        ss_d  = (ss_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = c_bit;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = ss_d;
          cout_d  = c_bit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q != RUN);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a cycle-level behavioural model of the
// 8-bit instance plus directed literal checks, and an exhaustive 1-bit instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset, start, start1, a1, b1;
  logic [7:0] a, b;
  logic       ready, done, cout;
  logic [7:0] sum;
  logic       ready1, done1, cout1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready), .sum(sum), .carry_out(cout), .done(done)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .sum(sum1), .carry_out(cout1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Model: an operation is a countdown of 8 edges ending in a result a+b.
  int         m_left = 0;
  logic [8:0] m_pend = '0;
  logic [7:0] m_sum  = '0;
  logic       m_cout = 1'b0;
  logic       m_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_cout, m_sum} = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend = {1'b0, a} + {1'b0, b};
        m_left = 8;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_ready", ready, m_left == 0);
    chk("model_done", done, m_done);
    chk("model_sum", sum, m_sum);
    chk("model_cout", cout, m_cout);
  end

  task automatic op8(input logic [7:0] xa, input logic [7:0] xb,
                     input logic [7:0] hold, output int lat);
    start = 1'b1; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      chk("hold_sum", sum, hold);
    end
    chk("latency", lat, 8);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, ndone, gap;
    int exp6[4] = '{0, 1, 1, 2};
    logic [1:0] v;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ready1", ready1, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Zero operands
    op8(8'h00, 8'h00, 8'h00, lat);
    chk("t1_sum", sum, 8'h00);
    chk("t1_cout", cout, 0);
    @(posedge clk); #1;

    // Overflow, then a result while the previous one must hold
    op8(8'hFF, 8'h01, 8'h00, lat);
    chk("t2a_sum", sum, 8'h00);
    chk("t2a_cout", cout, 1);
    @(posedge clk); #1;
    op8(8'hA5, 8'h5A, 8'h00, lat);
    chk("t2b_sum", sum, 8'hFF);
    chk("t2b_cout", cout, 0);
    @(posedge clk); #1;

    // start held during RUN and operands changed mid-operation
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    a = 8'h00; b = 8'h77;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("t3_ndone", ndone, 1);
    chk("t3_sum", sum, 8'h46);
    chk("t3_cout", cout, 0);

    // Asynchronous reset aborts an operation in flight
    start = 1'b1; a = 8'h80; b = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t4_ready", ready, 1);
    chk("t4_sum", sum, 0);
    chk("t4_cout", cout, 0);
    chk("t4_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("t4_ndone", ndone, 0);

    // Back-to-back: new start accepted in the DONE cycle
    op8(8'h0F, 8'h01, 8'h00, lat);
    chk("t5a_sum", sum, 8'h10);
    chk("t5_ready_done", ready, 1);
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_no_idle", ready, 0);
    chk("t5_done_fall", done, 0);
    gap = -1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        gap = k;
        break;
      end
      chk("t5_hold", sum, 8'h10);
    end
    chk("t5_gap", gap, 9);
    chk("t5b_sum", sum, 8'h30);
    chk("t5b_cout", cout, 0);
    @(posedge clk); #1;

    // WIDTH=1 exhaustive: registered half adder
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      start1 = 1'b1; a1 = v[1]; b1 = v[0];
      @(posedge clk); #1;
      start1 = 1'b0;
      @(posedge clk); #1;
      chk("t6_done", done1, 1);
      chk("t6_result", {cout1, sum1}, exp6[i]);
      @(posedge clk); #1;
      chk("t6_done_fall", done1, 0);
    end

    // Random traffic against the model
    repeat (500) begin
      start = ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
